arbiter_nb_rr: RTL and testbench
================================

// Module: arbiter_nb_rr
// PURPOSE
//  N-way four-phase request/acknowledge arbiter: merges N client channels onto one
//  shared req/ack channel and reports the granted index. Synchronous, single-clock
//  successor to the 2-input mutex arbiter. Adds generic width, round-robin or fixed
//  priority, optional input synchronisers and a sticky protocol-error flag.
// PARAMETERS
//  N            4   number of client channels, >= 2
//  RR_MODE      1   1: round-robin priority; 0: fixed priority, lowest index wins
//  SYNC_STAGES  2   flops on req_in[i] and ack_out; 0 = inputs already in clk domain
//  SEL_W        $clog2(N)   width of sel (localparam)
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      synchronous, active-high reset
//  req_in     in   N      client requests, four-phase, level
//  ack_in     out  N      client acknowledges, one-hot or zero
//  req_out    out  1      merged request to shared resource
//  ack_out    in   1      acknowledge from shared resource
//  sel        out  SEL_W  index of granted client, valid while busy=1
//  busy       out  1      a grant is in progress (state != IDLE)
//  proto_err  out  1      sticky: client dropped req_in before its ack_in rose
// BEHAVIOUR
//  - All outputs registered. Reset values: ack_in=0, req_out=0, sel=0, busy=0,
//    proto_err=0, RR pointer=0, state=IDLE. Reset mid-transaction aborts it at once.
//  - r[i], a = req_in / ack_out after SYNC_STAGES flops. All latencies below are
//    from r/a.
//  - FSM states:
//    IDLE: if any r, pick winner w, go to REQ next edge with req_out=1, sel=w,
//      busy=1. Latency: 1 clk after r visible.
//    REQ: hold req_out=1. On a=1, go to HOLD and set ack_in[sel]=1.
//    HOLD: hold ack_in[sel]=1. On r[sel]=0, go to RTZ and set req_out=0.
//    RTZ: ack_in[sel] stays 1. On a=0, set ack_in=0, busy=0, go to IDLE, and
//      update RR pointer to (sel+1) mod N.
//  - Full cycle per grant at zero sync and instant partners: 4 clk. IDLE may
//    re-grant on the edge after RTZ exits. No back-to-back grant in the same cycle.
//  - Winner: RR_MODE=1 picks the first set r scanning ptr, ptr+1 .. N-1, 0 ..
//    ptr-1. RR_MODE=0 picks the lowest set index, and the pointer is ignored.
//  - sel is stable from the REQ entry until the IDLE return. Requests arriving
//    during a grant are ignored until IDLE, with no queueing beyond the level.
//  - Simultaneous requests: exactly one wins; the others keep waiting, since
//    levels hold.
//  - r[sel] falling in REQ is a protocol violation: set proto_err. The FSM still
//    completes the handshake normally; HOLD exits on the first cycle.
//  - a dropping in HOLD is ignored. The FSM still waits for a=0 in RTZ.
//  - Non-selected ack_in bits are always 0. ack_in is never multi-hot.
//  - N not a power of two: sel never exceeds N-1, and pointer wrap is at N-1 -> 0.
// STRUCTURE
//  - Package arb_pkg: typedef enum logic [1:0] {IDLE, REQ, HOLD, RTZ} arb_state_t;
//    constants ARB_MODE_FIXED=0 and ARB_MODE_RR=1.
//  - Sub-module sync_chain #(STAGES, W): per-bit flop synchroniser, passes through
//    when STAGES=0. Instantiated twice (req_in width N, ack_out width 1).
//  - Winner selection is an internal function, a rotate-and-priority-encode;
//    it is not a separate module.
//  - Bench assertions: $onehot0(ack_in); sel<N; sel stable while busy.
// TESTING
//  (N=4, SYNC_STAGES=0, RR_MODE=1 unless noted; partner acks 1 clk after req_out edge)
//  1. Single client: req_in=4'b0100 -> next clk req_out=1, sel=2; ack_out=1 ->
//     ack_in=4'b0100; drop req -> req_out=0; ack_out=0 -> ack_in=0, busy=0.
//  2. Round-robin: req_in=4'b1111 held for 4 grants -> sel order 0,1,2,3,
//     then 0 again; each grant 4 clk.
//  3. Fixed priority (RR_MODE=0): req_in=4'b1010 held -> sel=1 every grant;
//    index 3 starves.
//  4. Late arrival: grant to 0 in HOLD, req_in[3] rises -> no effect until IDLE;
//    next sel=3.
//  5. Protocol error: in REQ, drop req_in[sel] -> proto_err=1; handshake
//    completes; flag stays 1 until rst.
//  6. Reset mid-grant: rst=1 in HOLD -> next clk all outputs 0, pointer=0;
//     SYNC_STAGES=2 rerun of test 1 -> req_out rises 3 clk after req_in.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and mode constants for the N-way four-phase arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        RTZ  = 2'd3
    } arb_state_t;

    localparam bit ARB_MODE_FIXED = 1'b0;
    localparam bit ARB_MODE_RR    = 1'b1;

endpackage

// File: rtl/sync_chain.sv
// Per-bit flop synchroniser of STAGES depth; a plain wire when STAGES is 0.
module sync_chain #(
    parameter int STAGES = 2,
    parameter int W      = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    if (STAGES == 0) begin : g_bypass
        logic unused_s;
        assign unused_s = clk ^ rst;
        assign q_o      = d_i;
    end else begin : g_chain
        logic [W-1:0] stage_q [STAGES];

        // Shift register, one stage per clock.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < STAGES; i++) begin
                    stage_q[i] <= '0;
                end
            end else begin
                stage_q[0] <= d_i;
                for (int i = 1; i < STAGES; i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign q_o = stage_q[STAGES-1];
    end

endmodule

// File: rtl/arbiter_nb_rr.sv
// N-way four-phase req/ack arbiter onto one shared channel, round-robin or fixed
// priority, with optional input synchronisers and a sticky protocol-error flag.
module arbiter_nb_rr
    import arb_pkg::*;
#(
    parameter int  N           = 4,
    parameter bit  RR_MODE     = ARB_MODE_RR,
    parameter int  SYNC_STAGES = 2,
    localparam int SEL_W       = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_in,
    output logic [N-1:0]     ack_in,
    output logic             req_out,
    input  logic             ack_out,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic             proto_err
);

    logic [N-1:0]     r_s;
    logic             a_s;
    logic [SEL_W-1:0] win_s;

    arb_state_t       state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [N-1:0]     ack_q, ack_d;
    logic             req_out_q, req_out_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;

    sync_chain #(.STAGES(SYNC_STAGES), .W(N)) u_req_sync (
        .clk (clk),
        .rst (rst),
        .d_i (req_in),
        .q_o (r_s)
    );

    sync_chain #(.STAGES(SYNC_STAGES), .W(1)) u_ack_sync (
        .clk (clk),
        .rst (rst),
        .d_i (ack_out),
        .q_o (a_s)
    );

    // Scan r starting at p with wrap at N-1; works for non-power-of-two N.
    function automatic logic [SEL_W-1:0] pick_winner(input logic [N-1:0] r,
                                                     input logic [SEL_W-1:0] p);
        logic [SEL_W:0] j;
        logic [SEL_W:0] idx;
        logic           found;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            j = {1'b0, p} + (SEL_W+1)'(i);
            if (j >= (SEL_W+1)'(N)) begin
                j = j - (SEL_W+1)'(N);
            end else begin
                j = j;
            end
            if (!found && r[j]) begin
                idx   = j;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return idx[SEL_W-1:0];
    endfunction

    assign win_s = pick_winner(r_s, (RR_MODE == ARB_MODE_RR) ? ptr_q : {SEL_W{1'b0}});

    // Next-state and next-output logic of the handshake FSM.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        ack_d     = ack_q;
        req_out_d = req_out_q;
        busy_d    = busy_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (|r_s) begin
                    state_d   = REQ;
                    req_out_d = 1'b1;
                    sel_d     = win_s;
                    busy_d    = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (!r_s[sel_q]) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q;
                end
                if (a_s) begin
                    state_d = HOLD;
                    ack_d   = {{(N-1){1'b0}}, 1'b1} << sel_q;
                end else begin
                    state_d = REQ;
                end
            end
            HOLD: begin
                if (!r_s[sel_q]) begin
                    state_d   = RTZ;
                    req_out_d = 1'b0;
                end else begin
                    state_d = HOLD;
                end
            end
            RTZ: begin
                if (!a_s) begin
                    state_d = IDLE;
                    ack_d   = '0;
                    busy_d  = 1'b0;
                    ptr_d   = (sel_q == SEL_W'(N-1)) ? {SEL_W{1'b0}} : sel_q + SEL_W'(1);
                end else begin
                    state_d = RTZ;
                end
            end
            default: begin
                state_d   = IDLE;
                ack_d     = '0;
                req_out_d = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            ptr_q     <= '0;
            ack_q     <= '0;
            req_out_q <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            ptr_q     <= ptr_d;
            ack_q     <= ack_d;
            req_out_q <= req_out_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    assign ack_in    = ack_q;
    assign req_out   = req_out_q;
    assign sel       = sel_q;
    assign busy      = busy_q;
    assign proto_err = err_q;

endmodule

// File: tb/tb_arbiter_nb_rr.sv
// Directed bench: per-cycle vector table on the round-robin, unsynchronised instance,
// plus hand sequences for fixed priority and two-stage synchronisers.
module tb_arbiter_nb_rr;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_in;
    logic       ack_out;
    logic [3:0] ack_in;
    logic       req_out;
    logic [1:0] sel;
    logic       busy;
    logic       proto_err;

    logic [3:0] f_req_in;
    logic       f_ack_out;
    logic [3:0] f_ack_in;
    logic       f_req_out;
    logic [1:0] f_sel;
    logic       f_busy;
    logic       f_proto_err;

    logic [3:0] s_req_in;
    logic       s_ack_out;
    logic [3:0] s_ack_in;
    logic       s_req_out;
    logic [1:0] s_sel;
    logic       s_busy;
    logic       s_proto_err;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    arbiter_nb_rr #(.N(4), .RR_MODE(1'b1), .SYNC_STAGES(0)) dut (
        .clk(clk), .rst(rst), .req_in(req_in), .ack_in(ack_in), .req_out(req_out),
        .ack_out(ack_out), .sel(sel), .busy(busy), .proto_err(proto_err));

    arbiter_nb_rr #(.N(4), .RR_MODE(1'b0), .SYNC_STAGES(0)) dut_fixed (
        .clk(clk), .rst(rst), .req_in(f_req_in), .ack_in(f_ack_in), .req_out(f_req_out),
        .ack_out(f_ack_out), .sel(f_sel), .busy(f_busy), .proto_err(f_proto_err));

    arbiter_nb_rr #(.N(4), .RR_MODE(1'b1), .SYNC_STAGES(2)) dut_sync (
        .clk(clk), .rst(rst), .req_in(s_req_in), .ack_in(s_ack_in), .req_out(s_req_out),
        .ack_out(s_ack_out), .sel(s_sel), .busy(s_busy), .proto_err(s_proto_err));

    always @(negedge clk) begin
        if (!rst) begin
            assert ($onehot0(ack_in)) else $error("ack_in multi-hot: %b", ack_in);
            assert (sel < 2'd3 || sel == 2'd3) else $error("sel out of range: %0d", sel);
        end
    end

    property p_sel_stable;
        @(posedge clk) disable iff (rst) (busy && $past(busy)) |-> (sel == $past(sel));
    endproperty
    a_sel_stable: assert property (p_sel_stable) else $error("sel changed while busy");

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       ack;
        logic [3:0] e_ack_in;
        logic       e_req_out;
        logic [1:0] e_sel;
        logic       chk_sel;
        logic       e_busy;
        logic       e_err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic [3:0] q, logic a, logic [3:0] ea,
                                logic er, logic [1:0] es, logic cs, logic eb, logic ee);
        vec_t v;
        v.rst = r; v.req = q; v.ack = a; v.e_ack_in = ea; v.e_req_out = er;
        v.e_sel = es; v.chk_sel = cs; v.e_busy = eb; v.e_err = ee;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] oh;
        logic [3:0] m;
        int         k;
        int         cnt;

        rst = 1'b1; req_in = 4'b0; ack_out = 1'b0;
        f_req_in = 4'b0; f_ack_out = 1'b0; s_req_in = 4'b0; s_ack_out = 1'b0;

        // single client
        tbl.push_back(mk(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0100, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b1, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0000, 1'b1, 4'b0100, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0));
        // round robin, all clients requesting, five grants
        tbl.push_back(mk(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0));
        for (int g = 0; g < 5; g++) begin
            k  = g % 4;
            oh = 4'b0001 << k;
            m  = 4'b1111 & ~oh;
            tbl.push_back(mk(1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'(k), 1'b1, 1'b1, 1'b0));
            tbl.push_back(mk(1'b0, 4'b1111, 1'b1, oh,      1'b1, 2'(k), 1'b1, 1'b1, 1'b0));
            tbl.push_back(mk(1'b0, m,       1'b1, oh,      1'b0, 2'(k), 1'b1, 1'b1, 1'b0));
            tbl.push_back(mk(1'b0, m,       1'b0, 4'b0000, 1'b0, 2'd0,  1'b0, 1'b0, 1'b0));
        end
        // late arrival of client 3 during a grant to 0, then pointer wrap 3 -> 0
        tbl.push_back(mk(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0001, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b1000, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b1000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'b1000, 1'b0, 4'b0000, 1'b1, 2'd3, 1'b1, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b1, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0000, 1'b1, 4'b1000, 1'b0, 2'd3, 1'b1, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'b1001, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b1000, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0));
        // protocol error: request dropped in REQ, flag sticky until reset
        tbl.push_back(mk(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0010, 1'b0, 4'b0000, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd1, 1'b1, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 4'b0000, 1'b1, 4'b0010, 1'b0, 2'd1, 1'b1, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 4'b0100, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b1, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1, 1'b1, 1'b1));
        // reset in HOLD: everything clears, pointer back to 0
        tbl.push_back(mk(1'b1, 4'b0100, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b1110, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0));

        foreach (tbl[i]) begin
            logic [8:0] got;
            logic [8:0] exp;
            rst     = tbl[i].rst;
            req_in  = tbl[i].req;
            ack_out = tbl[i].ack;
            tick();
            got = {ack_in, req_out, (tbl[i].chk_sel ? sel : 2'd0), busy, proto_err};
            exp = {tbl[i].e_ack_in, tbl[i].e_req_out, tbl[i].e_sel, tbl[i].e_busy, tbl[i].e_err};
            chk($sformatf("row%0d {ack_in,req_out,sel,busy,err}", i), 32'(got), 32'(exp));
        end
        rst = 1'b0; req_in = 4'b0; ack_out = 1'b0;

        // fixed priority: 1 wins every time, 3 starves
        f_req_in = 4'b1010;
        for (int g = 0; g < 3; g++) begin
            tick();
            chk($sformatf("fixed g%0d sel", g), 32'(f_sel), 32'd1);
            chk($sformatf("fixed g%0d req_out", g), 32'(f_req_out), 32'd1);
            f_ack_out = 1'b1;
            tick();
            chk($sformatf("fixed g%0d ack_in", g), 32'(f_ack_in), 32'b0010);
            f_req_in = 4'b1000;
            tick();
            chk($sformatf("fixed g%0d rtz req_out", g), 32'(f_req_out), 32'd0);
            f_ack_out = 1'b0;
            tick();
            chk($sformatf("fixed g%0d busy", g), 32'(f_busy), 32'd0);
            f_req_in = 4'b1010;
        end
        f_req_in = 4'b0000;

        // two-stage synchronisers: req_out 3 clk after req_in
        s_req_in = 4'b0100;
        tick();
        chk("sync req_out @1", 32'(s_req_out), 32'd0);
        tick();
        chk("sync req_out @2", 32'(s_req_out), 32'd0);
        tick();
        chk("sync req_out @3", 32'(s_req_out), 32'd1);
        chk("sync sel", 32'(s_sel), 32'd2);
        s_ack_out = 1'b1;
        tick();
        tick();
        chk("sync ack_in @2", 32'(s_ack_in), 32'd0);
        tick();
        chk("sync ack_in @3", 32'(s_ack_in), 32'b0100);
        s_req_in  = 4'b0000;
        s_ack_out = 1'b0;
        cnt = 0;
        while (s_busy && cnt < 10) begin
            tick();
            cnt++;
        end
        chk("sync busy drop clocks", 32'(cnt), 32'd4);
        chk("sync ack_in idle", 32'(s_ack_in), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
